dmem_bus_ctrl: RTL
==================

# dmem_bus_ctrl

Data-memory bus controller directly downstream of the MEM stage. Takes the stage's memory request (`mem_ce`, `mem_we`, `mem_addr`, `mem_data`) and runs it as a req/ack transaction on a variable-latency external data bus. Returns read data to the MEM stage and asserts a stall request to the pipeline control until the access completes. Includes a bus timeout and word-alignment checking.

## Interface
Parameters:
- `TIMEOUT`, 16: BUSY cycles without `bus_ack_i` before the access is aborted; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_ce_i`  in  1  access enable from the MEM stage.
- `mem_we_i`  in  1  1 = store word (SW), 0 = load word (LW).
- `mem_addr_i`  in  32  byte address.
- `mem_data_i`  in  32  store data.
- `mem_data_o`  out  32  load data returned to the MEM stage.
- `stallreq_o`  out  1  pipeline stall request.
- `misalign_o`  out  1  combinational; access address not word-aligned.
- `bus_err_o`  out  1  one-cycle pulse; access aborted by timeout.
- `bus_req_o`  out  1  bus request, registered.
- `bus_we_o`  out  1  bus write, registered.
- `bus_addr_o`  out  32  bus word address (`{mem_addr_i[31:2],2'b00}`), registered.
- `bus_wdata_o`  out  32  bus write data, registered.
- `bus_rdata_i`  in  32  bus read data, valid when `bus_ack_i`=1.
- `bus_ack_i`  in  1  bus completion.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `start = mem_ce_i & (mem_addr_i[1:0]==2'b00)`.
  - When `start`: `stallreq_o`=1 (combinational). Register `bus_req_o`=1, `bus_we_o`, `bus_addr_o`, `bus_wdata_o` (`mem_data_i` on writes, 0 on reads). Clear the timeout counter. Go to BUSY.
  - `mem_ce_i` with misaligned address: `misalign_o`=1, no bus request, no stall, `mem_data_o`=0, stay IDLE.
  - `bus_ack_i` in IDLE is ignored.
- BUSY:
  - `stallreq_o`=1. `bus_req_o`, `bus_we_o`, `bus_addr_o` and `bus_wdata_o` hold stable.
  - On `bus_ack_i`=1: drop `bus_req_o` next edge, capture `bus_rdata_i` into the read latch (reads only; writes leave it 0), go to DONE.
  - Without ack: counter increments. When it reaches `TIMEOUT-1` and ack is still 0: drop request, read latch = 0, pulse `bus_err_o` for one cycle (registered, high during DONE), go to DONE.
  - Ack in the same cycle as timeout expiry: ack wins, no error.
- DONE:
  - `stallreq_o`=0. `mem_data_o` = read latch. The MEM stage consumes the data at this edge.
  - Unconditionally go to IDLE. `mem_ce_i` seen in DONE belongs to the completing instruction and is not restarted.
- `mem_data_o` = 0 in IDLE and BUSY.
- Reset values: state IDLE, `bus_req_o`=0, `bus_we_o`=0, `bus_addr_o`=0, `bus_wdata_o`=0, read latch 0, counter 0, `bus_err_o`=0. Combinational outputs derived from IDLE: `stallreq_o`=0, `mem_data_o`=0.
- `rst` asserted mid-transaction drops `bus_req_o` immediately (asynchronously). The bus slave tolerates request withdrawal.

## Timing
- Minimum access, ack in the first BUSY cycle: 3 cycles (IDLE, BUSY, DONE), of which 2 are stall cycles.
- With ack in the Nth BUSY cycle: N+2 cycles, N+1 stall cycles.
- Timeout access: `TIMEOUT`+2 cycles.
- Back-to-back accesses: the next access starts in the IDLE cycle immediately after DONE, with no dead cycle beyond DONE.
- `bus_req_o` rises one edge after `start` and falls on the edge after ack is sampled.

## Test plan
- Reset, then LW at 0x00000010; slave acks in the first BUSY cycle with 0xDEADBEEF. Required: `bus_req_o` high 1 cycle, `bus_addr_o`=0x10, `bus_we_o`=0, stall high 2 cycles, `mem_data_o`=0xDEADBEEF in DONE.
- SW 0x12345678 to 0x00000020, ack after 3 BUSY cycles. Required: `bus_we_o`=1, `bus_wdata_o`=0x12345678 stable 3 cycles, stall high 4 cycles, `mem_data_o`=0.
- LW at 0x00000040, `TIMEOUT`=4, no ack. Required: `bus_req_o` high 4 cycles then low, `bus_err_o` high exactly 1 cycle, `mem_data_o`=0, return to IDLE.
- LW at 0x00000042. Required: `misalign_o`=1, `stallreq_o`=0, `bus_req_o` stays 0.
- LW then SW back-to-back, both acked immediately. Required: second `bus_req_o` rises 1 edge after first DONE, total 6 cycles. Ack arriving exactly in timeout cycle: no `bus_err_o`.
- Assert `rst` during BUSY. Required: `bus_req_o` and `stallreq_o` drop without waiting for a clock edge; after release the state is IDLE.

Source files
------------

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns a MEM-stage load/store into a req/ack bus
// transaction, stalling the pipeline until it completes or times out.
module dmem_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;

  logic aligned;
  logic start;

  assign aligned = (mem_addr_i[1:0] == 2'b00);
  assign start   = (state_q == S_IDLE) && mem_ce_i && aligned;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = {mem_addr_i[31:2], 2'b00};
          bus_wdata_d = mem_we_i ? mem_data_i : 32'd0;
          rdata_d     = 32'd0;
          cnt_d       = 8'd0;
        end
      end
      S_BUSY: begin
        // An ack in the expiry cycle still completes the access normally.
        if (bus_ack_i) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          rdata_d   = bus_we_q ? 32'd0 : bus_rdata_i;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          rdata_d   = 32'd0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      cnt_q       <= 8'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Gated by rst so a held request from the stalled MEM stage cannot keep
  // the pipeline frozen while reset is asserted.
  assign stallreq_o  = ~rst & (start | (state_q == S_BUSY));
  assign misalign_o  = (state_q == S_IDLE) & mem_ce_i & ~aligned;
  assign mem_data_o  = (state_q == S_DONE) ? rdata_q : 32'd0;
  assign bus_err_o   = bus_err_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule
